rbs_share_arbiter: RTL and testbench

//  Shares one u_rbs 8-bit ripple-borrow subtractor among NUM_REQ requesters (e.g. per-thread ALU lanes).

---
 rtl/rbs_pkg.sv | 15 +
 rtl/rbs.sv | 23 ++
 rtl/rbs_share_arbiter_rr_picker.sv | 32 +++
 rtl/rbs_share_arbiter.sv | 91 +++++++++
 tb/tb_rbs_share_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rbs_pkg.sv
// Shared widths and response record for the ripple-borrow subtractor slice.
// Pure type/constant package; no logic.
package rbs_pkg;

  localparam int RBS_W     = 8;
  localparam int RBS_OUT_W = 9;
  localparam int MAX_ID_W  = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [RBS_W-1:0]    diff;
    logic                borrow;
  } rbs_rsp_t;

endpackage

// File: rtl/rbs.sv
// 8-bit ripple-borrow subtractor: out[7:0] = a-b mod 256, out[8] = borrow (a<b).
// Purely combinational, no backpressure.
module rbs
  import rbs_pkg::*;
(
  input  logic [RBS_W-1:0]     a,
  input  logic [RBS_W-1:0]     b,
  output logic [RBS_OUT_W-1:0] out
);

  logic [RBS_W:0] brw;

  always_comb begin
    brw = '0;
    out = '0;
    for (int i = 0; i < RBS_W; i++) begin
      out[i]     = a[i] ^ b[i] ^ brw[i];
      brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
    out[RBS_W] = brw[RBS_W];
  end

endmodule

// File: rtl/rbs_share_arbiter_rr_picker.sv
// Round-robin picker: first set request after ptr (wrapping), one-hot grant plus index.
// Combinational; en=0 forces an all-zero grant.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int  cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rbs_share_arbiter.sv
// Shares one rbs subtractor among NUM_REQ requesters via round-robin grant.
// Latency: grant cycle N -> rsp_valid at N+2; 1 op/cycle while rsp_ready holds high.
// Backpressure: rsp_valid & !rsp_ready freezes S2; S1 holds when full; grants stop when both full.
module rbs_share_arbiter
  import rbs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*RBS_W-1:0] req_a,
  input  logic [NUM_REQ*RBS_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RBS_W-1:0]         rsp_diff,
  output logic                     rsp_borrow,
  output logic [CNT_W-1:0]         op_count
);

  logic                 v1;
  logic [RBS_W-1:0]     a1, b1;
  logic [ID_W-1:0]      id1, ptr, win_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 s1_en, s2_en, gnt_any;
  logic [RBS_OUT_W-1:0] rbs_out;
  rbs_rsp_t             s2;

  assign s2_en   = !rsp_valid || rsp_ready;
  assign s1_en   = !v1 || s2_en;
  assign gnt_any = |gnt;
  assign req_ready = gnt;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .en  (s1_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  // Operand stage; the pointer only moves on an accepted grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      id1      <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
      op_count <= '0;
    end else if (s1_en) begin
      v1 <= gnt_any;
      if (gnt_any) begin
        a1  <= req_a[win_idx*RBS_W +: RBS_W];
        b1  <= req_b[win_idx*RBS_W +: RBS_W];
        id1 <= win_idx;
        ptr <= win_idx;
        if (op_count != '1) op_count <= op_count + 1'b1;
      end
    end
  end

  rbs u_rbs (
    .a   (a1),
    .b   (b1),
    .out (rbs_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      s2        <= '0;
    end else if (s2_en) begin
      rsp_valid <= v1;
      if (v1) begin
        s2.id     <= MAX_ID_W'(id1);
        s2.diff   <= rbs_out[RBS_W-1:0];
        s2.borrow <= rbs_out[RBS_W];
      end
    end
  end

  assign rsp_id     = ID_W'(s2.id);
  assign rsp_diff   = s2.diff;
  assign rsp_borrow = s2.borrow;

endmodule

// File: tb/tb_rbs_share_arbiter.sv
// Directed and random stimulus for rbs_share_arbiter against an in-order transaction model.
module tb_rbs_share_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [8*N-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_diff;
  logic           rsp_borrow;
  logic [15:0]    op_count;

  rbs_share_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: ops accepted but not yet consumed, oldest first, tagged with grant cycle.
  typedef struct {
    int id;
    int diff;
    int brw;
    int c;
  } exp_t;

  exp_t q[$];
  int   ptr = N - 1;
  int   cnt = 0;
  int   now = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N-1:0] put(input int i, input int val);
    logic [8*N-1:0] r;
    r = '0;
    r[8*i +: 8] = 8'(val);
    return r;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                      input logic rdy, output logic [N-1:0] g);
    int   w, ai, bi, idx;
    logic exp_rv;
    exp_t e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
    // Room exists unless two ops are pending and the consumer is stalled.
    w = -1;
    if (v != '0 && (q.size() < 2 || rdy)) begin
      for (int k = 1; k <= N; k++) begin
        idx = (ptr + k) % N;
        if (w < 0 && v[idx]) w = idx;
      end
    end
    exp_rv = (q.size() > 0) && (now >= q[0].c + 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), q[0].id);
      chk("rsp_diff", 32'(rsp_diff), q[0].diff);
      chk("rsp_borrow", 32'(rsp_borrow), q[0].brw);
    end
    chk("req_ready", 32'(req_ready), (w < 0) ? 0 : (1 << w));
    chk("op_count", 32'(op_count), cnt);
    g = req_ready;
    if (exp_rv && rdy) void'(q.pop_front());
    if (w >= 0) begin
      ai     = int'(a[8*w +: 8]);
      bi     = int'(b[8*w +: 8]);
      e.id   = w;
      e.diff = (ai - bi) & 255;
      e.brw  = (ai < bi) ? 1 : 0;
      e.c    = now;
      q.push_back(e);
      ptr = w;
      if (cnt < 65535) cnt++;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_op_count", 32'(op_count), 0);
    q.delete();
    ptr = N - 1;
    cnt = 0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    logic [N-1:0]   g;
    logic [N-1:0]   gl [5];
    logic [8*N-1:0] ra, rb;
    int             gcnt;

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    chk("init_rsp_valid", 32'(rsp_valid), 0);
    chk("init_rsp_id", 32'(rsp_id), 0);
    chk("init_rsp_diff", 32'(rsp_diff), 0);
    chk("init_rsp_borrow", 32'(rsp_borrow), 0);
    chk("init_op_count", 32'(op_count), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 0
    step(4'b0001, put(0, 200), put(0, 55), 1'b1, g);
    chk("t1_gnt", 32'(g), 1);
    step('0, '0, '0, 1'b1, g);
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_diff", 32'(rsp_diff), 145);
    chk("t1_borrow", 32'(rsp_borrow), 0);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_count", 32'(op_count), 1);
    step('0, '0, '0, 1'b1, g);

    // Underflow and zero operands
    step(4'b0100, put(2, 5), put(2, 10), 1'b1, g);
    step('0, '0, '0, 1'b1, g);
    chk("t2_diff", 32'(rsp_diff), 251);
    chk("t2_borrow", 32'(rsp_borrow), 1);
    chk("t2_id", 32'(rsp_id), 2);
    step('0, '0, '0, 1'b1, g);
    step(4'b0010, put(1, 0), put(1, 0), 1'b1, g);
    step('0, '0, '0, 1'b1, g);
    chk("t2z_diff", 32'(rsp_diff), 0);
    chk("t2z_borrow", 32'(rsp_borrow), 0);
    chk("t2z_id", 32'(rsp_id), 1);
    step('0, '0, '0, 1'b1, g);

    // All requesters valid, consumer always ready
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ra = {$urandom};
      rb = {$urandom};
      step('1, ra, rb, 1'b1, g);
      gl[i] = g;
    end
    chk("rr_g0", 32'(gl[0]), 1);
    chk("rr_g1", 32'(gl[1]), 2);
    chk("rr_g2", 32'(gl[2]), 4);
    chk("rr_g3", 32'(gl[3]), 8);
    chk("rr_g4", 32'(gl[4]), 1);
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, g);

    // Stalled consumer: only two ops fit in the pipeline
    gcnt = 0;
    for (int i = 0; i < 5; i++) begin
      ra = {$urandom};
      rb = {$urandom};
      step('1, ra, rb, 1'b0, g);
      gcnt += $countones(g);
    end
    chk("stall_grants", gcnt, 2);
    for (int i = 0; i < 4; i++) step('0, '0, '0, 1'b1, g);
    chk("stall_drained", q.size(), 0);
    chk("stall_rsp_idle", 32'(rsp_valid), 0);

    // Reset with both stages full
    step('1, {$urandom}, {$urandom}, 1'b0, g);
    step('1, {$urandom}, {$urandom}, 1'b0, g);
    do_reset();
    step('1, {$urandom}, {$urandom}, 1'b1, g);
    chk("rst_first_gnt", 32'(g), 1);
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, g);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom};
      rb = {$urandom};
      if ($urandom_range(0, 15) == 0) rb = ra;
      step(N'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) != 0), g);
    end
    for (int i = 0; i < 4; i++) step('0, '0, '0, 1'b1, g);
    chk("rand_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
